// File: rtl/div_sched_pkg.sv
// Shared types and sizing helpers for the stochastic divider session scheduler.
package div_sched_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;

  // Phase counter must hold the longest of the clear, warm-up and run windows.
  function automatic int phase_w(input int clr_cyc, input int warm_cyc, input int len_log);
    int m;
    m = 1 << len_log;
    if (clr_cyc > m) m = clr_cyc;
    if (warm_cyc > m) m = warm_cyc;
    return $clog2(m + 1);
  endfunction

  // One extra bit so an all-ones window (2^LEN_LOG) does not wrap.
  function automatic int acc_w(input int len_log);
    return len_log + 1;
  endfunction

endpackage

// File: rtl/div_stream_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after pointer, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] pointer,
  input  logic           update,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id,
  output logic           valid
);

  always_comb begin
    int idx;
    logic [N-1:0] req_sh;
    grant = '0;
    id    = '0;
    valid = 1'b0;
    // Scan from farthest to nearest so the nearest hit is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(pointer) + k;
      if (idx >= N) idx = idx - N;
      req_sh = req >> idx;
      if (update && req_sh[0]) begin
        grant = N'(1) << idx;
        id    = IDW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_stream_sched.sv
// Time-shares one bipolar stochastic divider between N_REQ requesters.
// Optional sat output enabled by defining DIV_SCHED_SAT_EN.
module div_stream_sched
  import div_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int LEN_LOG  = 8,
  parameter int CLR_CYC  = 2,
  parameter int WARM_CYC = 8,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   dividend_in,
  input  logic [N_REQ-1:0]   divisor_in,
  output logic [N_REQ-1:0]   grant,
  output logic               div_dividend,
  output logic               div_divisor,
  output logic               div_clr,
  input  logic               div_quotient,
  output logic               done,
  output logic [IDW-1:0]     done_id,
  output logic [LEN_LOG:0]   ones_cnt
`ifdef DIV_SCHED_SAT_EN
  ,
  output logic               sat
`endif
);

  localparam int PW      = phase_w(CLR_CYC, WARM_CYC, LEN_LOG);
  localparam int AW      = acc_w(LEN_LOG);
  localparam int RUN_LEN = 1 << LEN_LOG;

  state_t           state_reg, state_next;
  logic [PW-1:0]    phase_reg, phase_next;
  logic [AW-1:0]    acc_reg, acc_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic             done_reg, done_next;
  logic [IDW-1:0]   done_id_reg, done_id_next;
  logic [AW-1:0]    ones_reg, ones_next;
  logic [AW-1:0]    acc_sum;
  logic [IDW-1:0]   id_after;
  logic             owner_req;

  logic [N_REQ-1:0] arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_valid;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
    .req     (req),
    .pointer (ptr_reg),
    .update  (state_reg == IDLE),
    .grant   (arb_grant),
    .id      (arb_id),
    .valid   (arb_valid)
  );

  assign owner_req    = |(req & grant_reg);
  assign acc_sum      = acc_reg + AW'(div_quotient);
  assign id_after     = (id_reg == IDW'(N_REQ - 1)) ? '0 : id_reg + IDW'(1);
  assign div_dividend = |(dividend_in & grant_reg);
  assign div_divisor  = |(divisor_in & grant_reg);
  assign div_clr      = (state_reg == IDLE) || (state_reg == CLEAR);
  assign grant        = grant_reg;
  assign done         = done_reg;
  assign done_id      = done_id_reg;
  assign ones_cnt     = ones_reg;

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    acc_next     = acc_reg;
    id_next      = id_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    done_next    = 1'b0;
    done_id_next = done_id_reg;
    ones_next    = ones_reg;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          grant_next = arb_grant;
          id_next    = arb_id;
          phase_next = '0;
          state_next = CLEAR;
        end
      end
      CLEAR, WARM, RUN: begin
        if (!owner_req) begin
          // Owner withdrew: drop the session silently and move past it.
          state_next = IDLE;
          grant_next = '0;
          phase_next = '0;
          ptr_next   = id_after;
        end else if (state_reg == CLEAR) begin
          phase_next = phase_reg + PW'(1);
          if (phase_reg == PW'(CLR_CYC - 1)) begin
            state_next = WARM;
            phase_next = '0;
          end
        end else if (state_reg == WARM) begin
          phase_next = phase_reg + PW'(1);
          if (phase_reg == PW'(WARM_CYC - 1)) begin
            state_next = RUN;
            phase_next = '0;
            acc_next   = '0;
          end
        end else begin
          acc_next   = acc_sum;
          phase_next = phase_reg + PW'(1);
          if (phase_reg == PW'(RUN_LEN - 1)) begin
            state_next   = DONE;
            phase_next   = '0;
            done_next    = 1'b1;
            done_id_next = id_reg;
            ones_next    = acc_sum;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        ptr_next   = id_after;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      acc_reg     <= '0;
      id_reg      <= '0;
      ptr_reg     <= '0;
      grant_reg   <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      ones_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      acc_reg     <= acc_next;
      id_reg      <= id_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
      ones_reg    <= ones_next;
    end
  end

`ifdef DIV_SCHED_SAT_EN
  logic sat_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_reg <= 1'b0;
    else if (done_next)
      sat_reg <= (acc_sum == '0) || (acc_sum == AW'(RUN_LEN));
  end
  assign sat = sat_reg;
`endif

endmodule

// File: doc/div_stream_sched.md
Name: div_stream_sched

Overview:
- Shares one bipolar stochastic divider kernel (Abs → Bi2Uni → unipolar ISC divider → Uni2Bi chain) between N_REQ requesters.
- Grants requesters round-robin and drives the kernel's soft clear.
- Routes the granted requester's dividend/divisor bitstreams to the kernel and discards pipeline warm-up output.
- Counts quotient ones over a 2^LEN_LOG-cycle window and returns the count with a done pulse.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- LEN_LOG, 8, log2 of the measured bitstream length.
- CLR_CYC, 2, cycles div_clr is held high before a session (≥1).
- WARM_CYC, 8, cycles of discarded kernel output after clear; covers the Abs, Bi2Uni, kernel and sync depths (≥1).
- IDW, $clog2(N_REQ), requester id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  N_REQ  per-requester session request; level, held until done for that id.
- dividend_in  in  N_REQ  per-requester bipolar dividend bitstream.
- divisor_in  in  N_REQ  per-requester bipolar divisor bitstream.
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- div_dividend  out  1  to kernel dividend.
- div_divisor  out  1  to kernel divisor.
- div_clr  out  1  kernel soft clear, active high.
- div_quotient  in  1  kernel bipolar quotient bit.
- done  out  1  one-cycle session-complete pulse.
- done_id  out  IDW  id of the completed session; valid with done.
- ones_cnt  out  LEN_LOG+1  quotient ones counted over the RUN window; valid with done, held until next done.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, div_clr=1, done=0, done_id=0, ones_cnt=0.
  - Round-robin pointer=0, so id 0 has top priority first.
  - Applies immediately, including mid-session. No done is issued for an interrupted session.
- Datapath mux:
  - div_dividend and div_divisor are combinationally muxed from dividend_in/divisor_in[granted id] while grant≠0.
  - Both are 0 when grant=0.
- IDLE:
  - div_clr=1.
  - If any req bit is set, pick the first set bit at or after the pointer, wrapping.
  - Next cycle: grant=onehot(id), state=CLEAR, phase counter=0.
- CLEAR: div_clr=1 for CLR_CYC cycles, then state=WARM.
- WARM: div_clr=0; div_quotient is ignored for WARM_CYC cycles; then state=RUN and the accumulator is cleared.
- RUN:
  - Lasts 2^LEN_LOG cycles; the accumulator increments when div_quotient=1.
  - Accumulator width is LEN_LOG+1, so no wrap (max 2^LEN_LOG).
  - Then state=DONE.
- DONE (1 cycle):
  - done=1, done_id=id, ones_cnt=accumulator.
  - Pointer=id+1 mod N_REQ.
  - grant stays asserted this cycle; state=IDLE next.
- Latency: done is asserted exactly CLR_CYC+WARM_CYC+2^LEN_LOG cycles after the first cycle grant is high.
- Abort: if req[id] drops during CLEAR, WARM or RUN:
  - Next cycle state=IDLE, grant=0, div_clr=1.
  - No done; ones_cnt unchanged; pointer=id+1.
- req changes of non-granted ids have no effect until IDLE.
- A requester re-asserting req in the DONE cycle waits its round-robin turn.
- The bipolar value is 2·ones_cnt/2^LEN_LOG − 1; conversion is the consumer's job.

Optional Feature:
- Macro: DIV_SCHED_SAT_EN.
- Defined: adds output port sat (1 bit).
  - sat is reset 0 and updated with done.
  - sat=1 when ones_cnt==0 or ones_cnt==2^LEN_LOG, i.e. the quotient saturated at ±1 (|divisor| ≤ |dividend|).
  - sat=0 otherwise.
- Undefined: no sat port and no comparison logic; all other behaviour is identical.

Decomposition:
- Package div_sched_pkg holds:
  - state enum {IDLE, CLEAR, WARM, RUN, DONE};
  - phase counter width, $clog2 of max(CLR_CYC, WARM_CYC, 2^LEN_LOG)+1;
  - accumulator width LEN_LOG+1.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req, pointer, update strobe.
  - Outputs: one-hot grant, encoded id.
  - Purely combinational pick; the pointer register lives in the scheduler.

Test Plan:
- Single requester: req=4'b0001, div_quotient forced 1, LEN_LOG=8, CLR=2, WARM=8.
  - grant=0001 one cycle after req.
  - done 266 cycles after grant rises; done_id=0, ones_cnt=256.
- Round-robin: req=4'b1111 held, quotient tied to a counter LSB (alternating).
  - Done ids come in order 0,1,2,3,0, each with ones_cnt=128.
  - grant is never multi-hot.
- Warm-up discard: quotient=1 only during CLEAR/WARM and 0 in RUN → ones_cnt=0.
  - Quotient=1 only in the last RUN cycle → ones_cnt=1.
- Abort: req[2] dropped 50 cycles into RUN.
  - grant=0 next cycle, div_clr=1, no done, prior ones_cnt unchanged.
  - Next grant goes to id 3 if it is requesting.
- Reset mid-RUN: rst_n low for 1 cycle.
  - grant=0, div_clr=1, done=0, ones_cnt=0 immediately.
  - The next session starts from id 0.
- DIV_SCHED_SAT_EN:
  - ones_cnt=256 → sat=1.
  - ones_cnt=0 → sat=1.
  - ones_cnt=128 → sat=0.
